uart_receiver_fsm: RTL and testbench
====================================

// Module: uart_receiver_fsm
// PURPOSE
//  Receive path of the APB-UART bridge. Oversamples the serial line on UCLK and detects the start bit.
//  Samples each bit at mid-bit, deserialises DATA_WIDTH bits LSB first, and checks the optional parity bit and the stop bit.
//  Presents each completed byte to the APB side with a one-cycle data_valid strobe and error flags.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame
//  PRESCALE    16  UCLK cycles per bit; even, >= 8
// PORTS
//  UCLK           in   1           receiver clock (PRESCALE x baud)
//  reset          in   1           asynchronous, active-low
//  rx_in          in   1           raw serial line (idle high)
//  parity_enable  in   1           1 = frame carries a parity bit
//  parity_type    in   1           0 = even, 1 = odd
//  data_out       out  DATA_WIDTH  last received byte
//  data_valid     out  1           one-cycle strobe: data_out and flags updated
//  parity_error   out  1           parity mismatch in last frame
//  framing_error  out  1           stop bit sampled 0 in last frame
//  busy           out  1           frame reception in progress
// BEHAVIOUR
//  - Reset: state IDLE; counters 0; 2-flop rx synchroniser = 1; data_out=0; data_valid=0; parity_error=0; framing_error=0; busy=0.
//  - rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//  - Cycle counter ec: 0..PRESCALE-1, wraps. Cleared on entering START. Counts every cycle outside IDLE.
//  - Bit index bi: 0..DATA_WIDTH-1. Increments on each ec wrap in DATA.
//  - Decision cycle S: ec == PRESCALE/2-1 (7 for PRESCALE=16). Sample = rx_s at S.
//  - States: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: rx_s==0 -> START, ec=0. parity_enable and parity_type are latched here and are ignored for the rest of the frame.
//  - START: sample==1 at S -> IDLE (glitch). No strobe, flags unchanged.
//    Otherwise, at ec==PRESCALE-1 -> DATA, bi=0.
//  - DATA: at S, shift sample into shift reg MSB, i.e. LSB first.
//    At ec==PRESCALE-1 with bi==DATA_WIDTH-1 -> PARITY if the latched parity_enable is 1, else STOP.
//  - PARITY: at S, perr = sample ^ (^shift) ^ parity_type. At ec==PRESCALE-1 -> STOP.
//  - STOP: at S, in one cycle:
//    - data_out <= shift; data_valid <= 1; framing_error <= ~sample
//    - parity_error <= perr if parity enabled, else 0
//    - state -> IDLE immediately (half-bit early), so a back-to-back start bit is caught.
//  - data_valid is high exactly one cycle per completed frame, errored frames included. data_out and the flags hold until the next completed frame.
//  - busy = (state != IDLE), combinational from state.
//  - rx_s held low after a framing error: re-enters START immediately and is treated as a new frame (break is not special-cased).
//  - reset asserted mid-frame: all outputs return to reset values asynchronously and the partial frame is discarded.
//  - Latency: falling edge on rx_in -> busy high 3 UCLK later. Stop-bit centre -> data_valid on the following edge.
// CONFIGURATION
//  - UART_RX_MAJORITY_VOTE_EN defined:
//    - each sample = majority of rx_s at ec = PRESCALE/2-2, PRESCALE/2-1, PRESCALE/2
//    - decision cycle S moves to ec == PRESCALE/2
//    - a single-cycle glitch at mid-bit is rejected
//  - Not defined: single sample at ec == PRESCALE/2-1, no vote registers.
// TESTING
//  1. PRESCALE=16, parity off, send 0x55 (start,10101010,stop) -> data_out=0x55, data_valid 1 cycle, both flags 0, busy low after strobe.
//  2. Even parity, send 0xA3 with parity bit 0 -> parity_error=0. Resend with parity bit 1 -> parity_error=1, data_out=0xA3.
//  3. Odd parity, send 0x00 with parity bit 1 -> parity_error=0.
//  4. Send 0x3C with stop bit 0 -> framing_error=1, data_out=0x3C. Then a valid 0x81 -> framing_error=0, data_out=0x81.
//  5. rx_in low for 4 cycles then high -> busy pulses, returns IDLE, no data_valid, outputs unchanged.
//  6. Two frames 0x12, 0x34 back-to-back, no idle gap -> two strobes, data_out 0x12 then 0x34, no errors.
//     Assert reset mid-frame -> all outputs 0 at once, busy=0.
//     With UART_RX_MAJORITY_VOTE_EN: a 1-cycle high pulse at mid bit 2 of 0x00 -> data_out=0x00.

Source files
------------

// File: rtl/uart_receiver_fsm.sv
// UART receive FSM: 2-flop synchroniser, mid-bit sampling, LSB-first deserialise, parity/stop checks.
// Define UART_RX_MAJORITY_VOTE_EN to replace the single mid-bit sample with a 3-sample majority vote.
module uart_receiver_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] EC_LAST = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BI_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] EC_V0 = CW'(PRESCALE / 2 - 2);
  localparam logic [CW-1:0] EC_V1 = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] EC_S  = CW'(PRESCALE / 2);
`else
  localparam logic [CW-1:0] EC_S  = CW'(PRESCALE / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic                  rx_meta_q;
  logic                  rx_s_q;
  logic [CW-1:0]         ec_q;
  logic [BW-1:0]         bi_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  perr_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  parity_error_q;
  logic                  framing_error_q;
  logic                  sample;
  logic                  at_s;
  logic                  at_last;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote0_q;
  logic vote1_q;

  // The third vote is the live rx_s at the decision cycle itself.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else if (state_q != IDLE) begin
      if (ec_q == EC_V0) vote0_q <= rx_s_q;
      if (ec_q == EC_V1) vote1_q <= rx_s_q;
    end
  end

  assign sample = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  assign at_s    = (ec_q == EC_S);
  assign at_last = (ec_q == EC_LAST);

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      ec_q            <= '0;
      bi_q            <= '0;
      shift_q         <= '0;
      par_en_q        <= 1'b0;
      par_type_q      <= 1'b0;
      perr_q          <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx_in;
      rx_s_q       <= rx_meta_q;
      data_valid_q <= 1'b0;
      if (state_q != IDLE) ec_q <= at_last ? '0 : ec_q + CW'(1);
      case (state_q)
        IDLE: begin
          par_en_q   <= parity_enable;
          par_type_q <= parity_type;
          if (!rx_s_q) begin
            state_q <= START;
            ec_q    <= '0;
          end
        end
        START: begin
          if (at_s && sample) begin
            state_q <= IDLE;
          end else if (at_last) begin
            state_q <= DATA;
            bi_q    <= '0;
          end
        end
        DATA: begin
          if (at_s) shift_q <= {sample, shift_q[DATA_WIDTH-1:1]};
          if (at_last) begin
            if (bi_q == BI_LAST) state_q <= par_en_q ? PARITY : STOP;
            else                 bi_q    <= bi_q + BW'(1);
          end
        end
        PARITY: begin
          if (at_s)    perr_q  <= sample ^ (^shift_q) ^ par_type_q;
          if (at_last) state_q <= STOP;
        end
        STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          if (at_s) begin
            data_out_q      <= shift_q;
            data_valid_q    <= 1'b1;
            framing_error_q <= ~sample;
            parity_error_q  <= par_en_q & perr_q;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Directed-frame bench for uart_receiver_fsm with a frame-level timing/result model checked every cycle.
module tb_uart_receiver_fsm;
  localparam int DW = 8;
  localparam int PS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int S_EC = PS / 2;
`else
  localparam int S_EC = PS / 2 - 1;
`endif
  localparam int NCYC = 16384;

  logic          UCLK = 1'b0;
  logic          reset;
  logic          rx_in = 1'b1;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;

  uart_receiver_fsm #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .UCLK(UCLK), .reset(reset), .rx_in(rx_in),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .data_out(data_out), .data_valid(data_valid),
    .parity_error(parity_error), .framing_error(framing_error), .busy(busy)
  );

  always #5 UCLK = ~UCLK;

  int cyc = 0;
  always @(posedge UCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int nstrobe = 0;
  bit chk_en = 1'b0;

  // Model state: per-edge expectations plus the values the outputs must hold.
  bit            exp_busy [NCYC];
  bit            exp_vld  [NCYC];
  logic [DW+1:0] exp_rec  [NCYC];
  logic [DW-1:0] m_data = '0;
  logic          m_perr = 1'b0;
  logic          m_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge UCLK) begin
    if (data_valid === 1'b1) nstrobe++;
    if (chk_en && cyc < NCYC) begin
      if (exp_vld[cyc]) begin
        m_data = exp_rec[cyc][DW-1:0];
        m_ferr = exp_rec[cyc][DW];
        m_perr = exp_rec[cyc][DW+1];
      end
      check("data_valid",    data_valid,    exp_vld[cyc]);
      check("busy",          busy,          exp_busy[cyc]);
      check("data_out",      data_out,      m_data);
      check("framing_error", framing_error, m_ferr);
      check("parity_error",  parity_error,  m_perr);
    end
  end

  task automatic drive_bit(input logic b, input int gpos);
    for (int c = 0; c < PS; c++) begin
      rx_in = (c == gpos) ? ~b : b;
      @(posedge UCLK);
      #1;
    end
  endtask

  task automatic idle(input int nbits);
    repeat (nbits) drive_bit(1'b1, -1);
  endtask

  // A start seen at edge d with the line back high is rejected at the decision cycle.
  task automatic mark_glitch(input int d);
    for (int c = d; c <= d + S_EC; c++) exp_busy[c] = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit pbit, input bit stopb,
                            input int gbit, input int gpos);
    int k;
    int slot;
    int e;
    bit perr;
    k    = cyc;
    slot = 1 + DW + (parity_enable ? 1 : 0);
    // 2 sync flops + 1 detect edge, then mid-stop decision, then the strobe edge.
    e    = k + 3 + PS * slot + S_EC + 1;
    perr = parity_enable && ((($countones(d) + pbit) % 2) != parity_type);
    for (int c = k + 3; c < e; c++) exp_busy[c] = 1'b1;
    exp_vld[e] = 1'b1;
    exp_rec[e] = {perr, ~stopb, d};
    if (!stopb) mark_glitch(e + 1);
    drive_bit(1'b0, -1);
    for (int i = 0; i < DW; i++) drive_bit(d[i], (i == gbit) ? gpos : -1);
    if (parity_enable) drive_bit(pbit, -1);
    drive_bit(stopb, -1);
  endtask

  initial begin
    int s0;
    int k;
    reset = 1'b0;
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_error, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_busy", busy, 0);
    @(posedge UCLK); #1;
    reset = 1'b1;
    @(posedge UCLK); #1;
    chk_en = 1'b1;
    idle(1);

    // 1: plain 8N1
    s0 = nstrobe;
    send_frame(8'h55, 1'b0, 1'b1, -1, 0);
    idle(2);
    check("t1_data", data_out, 8'h55);
    check("t1_strobes", nstrobe - s0, 1);
    check("t1_flags", {parity_error, framing_error}, 2'b00);
    check("t1_busy", busy, 0);

    // 2: even parity, good then bad parity bit
    parity_enable = 1'b1; parity_type = 1'b0;
    send_frame(8'hA3, 1'b0, 1'b1, -1, 0);
    idle(2);
    check("t2_perr_ok", parity_error, 0);
    send_frame(8'hA3, 1'b1, 1'b1, -1, 0);
    idle(2);
    check("t2_perr_bad", parity_error, 1);
    check("t2_data", data_out, 8'hA3);

    // 3: odd parity
    parity_type = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, -1, 0);
    idle(2);
    check("t3_perr", parity_error, 0);
    check("t3_data", data_out, 8'h00);

    // 4: framing error then recovery
    parity_enable = 1'b0; parity_type = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
    idle(2);
    check("t4_ferr", framing_error, 1);
    check("t4_data", data_out, 8'h3C);
    send_frame(8'h81, 1'b0, 1'b1, -1, 0);
    idle(2);
    check("t4_ferr_clr", framing_error, 0);
    check("t4_data2", data_out, 8'h81);

    // 5: false start
    s0 = nstrobe;
    k = cyc;
    mark_glitch(k + 3);
    rx_in = 1'b0;
    repeat (4) begin @(posedge UCLK); #1; end
    idle(2);
    check("t5_strobes", nstrobe - s0, 0);
    check("t5_data", data_out, 8'h81);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // single-cycle high pulse centred on data bit 2 must be voted out
    send_frame(8'h00, 1'b0, 1'b1, 2, PS / 2);
    idle(2);
    check("mv_data", data_out, 8'h00);
`endif

    // 6: back-to-back frames
    s0 = nstrobe;
    send_frame(8'h12, 1'b0, 1'b1, -1, 0);
    check("t6_data1", data_out, 8'h12);
    send_frame(8'h34, 1'b0, 1'b1, -1, 0);
    idle(2);
    check("t6_strobes", nstrobe - s0, 2);
    check("t6_data2", data_out, 8'h34);
    check("t6_flags", {parity_error, framing_error}, 2'b00);

    // reset in the middle of a frame
    k = cyc;
    for (int c = k + 3; c <= k + 40; c++) exp_busy[c] = 1'b1;
    rx_in = 1'b0;
    repeat (16) begin @(posedge UCLK); #1; end
    rx_in = 1'b1;
    repeat (24) begin @(posedge UCLK); #1; end
    chk_en = 1'b0;
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_data_out", data_out, 0);
    check("arst_busy", busy, 0);
    check("arst_flags", {data_valid, parity_error, framing_error}, 3'b000);
    m_data = '0; m_perr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge UCLK);
    #1;
    reset = 1'b1;
    @(posedge UCLK); #1;
    chk_en = 1'b1;
    idle(1);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    idle(2);
    check("post_rst_data", data_out, 8'h5A);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
